// File: rtl/lab3_cache_arb_pkg.sv
// Shared types for the cache-to-memory arbiter: channel ids and 4-byte memory messages.
// The message fields are opaque to the arbiter; it passes them through unmodified.
package lab3_cache_arb_pkg;

  localparam int c_max_ports  = 8;
  localparam int c_chan_id_w  = $clog2(c_max_ports);

  typedef logic [c_chan_id_w-1:0] chan_id_t;

  typedef enum logic [2:0] {
    MEM_READ  = 3'd0,
    MEM_WRITE = 3'd1,
    MEM_INIT  = 3'd2
  } mem_msg_type_t;

  typedef struct packed {
    mem_msg_type_t msg_type;
    logic [7:0]    opaque;
    logic [31:0]   addr;
    logic [1:0]    len;
    logic [31:0]   data;
  } mem_req_4B_t;

  typedef struct packed {
    mem_msg_type_t msg_type;
    logic [7:0]    opaque;
    logic [1:0]    test;
    logic [1:0]    len;
    logic [31:0]   data;
  } mem_resp_4B_t;

  // Round-robin successor of a channel id among n channels.
  function automatic chan_id_t rr_next(input chan_id_t cur, input int n);
    if (int'(cur) >= n - 1) return '0;
    return cur + chan_id_t'(1);
  endfunction

endpackage

// File: rtl/lab3_cache_TagQueue.sv
// In-flight channel-id FIFO: records which cache issued each outstanding memory request.
// Push and pop are ignored when full / empty respectively; head is valid whenever !empty.
module lab3_cache_TagQueue
  import lab3_cache_arb_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  chan_id_t push_id,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output chan_id_t head
);

  localparam int c_ptr_w = $clog2(p_depth);

  chan_id_t             slots [p_depth];
  logic [c_ptr_w-1:0]   wr_ptr;
  logic [c_ptr_w-1:0]   rd_ptr;
  logic [c_ptr_w:0]     count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (c_ptr_w+1)'(p_depth));
  assign empty   = (count == '0);
  assign head    = slots[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/lab3_cache_mem_arbiter.sv
// Round-robin merge of p_num_ports cache memory ports onto one memory port, zero-cycle request path;
// responses return in issue order via a tag queue, and a full queue back-pressures all requesters.
module lab3_cache_mem_arbiter
  import lab3_cache_arb_pkg::*;
#(
  parameter int p_num_ports       = 2,
  parameter int p_max_outstanding = 4
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic [p_num_ports-1:0] cache_req_val,
  output logic [p_num_ports-1:0] cache_req_rdy,
  input  mem_req_4B_t            cache_req_msg  [p_num_ports],

  output logic [p_num_ports-1:0] cache_resp_val,
  input  logic [p_num_ports-1:0] cache_resp_rdy,
  output mem_resp_4B_t           cache_resp_msg [p_num_ports],

  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output mem_req_4B_t            mem_req_msg,

  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  mem_resp_4B_t           mem_resp_msg,

  input  logic [p_num_ports-1:0] cache_flush_done,
  input  logic                   flush,
  output logic                   flush_done
);

  chan_id_t               rr_ptr;
  chan_id_t               grant;
  logic                   any_val;
  logic                   found;
  logic                   req_fire;
  logic                   resp_fire;
  logic                   head_rdy;
  logic                   q_full;
  logic                   q_empty;
  chan_id_t               q_head;
  logic [p_num_ports-1:0] sticky;

  // Two passes: channels at or after the pointer first, then the wrapped-around ones.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < p_num_ports; i++) begin
      if (!found && cache_req_val[i] && (i >= int'(rr_ptr))) begin
        found = 1'b1;
        grant = chan_id_t'(i);
      end
    end
    for (int i = 0; i < p_num_ports; i++) begin
      if (!found && cache_req_val[i]) begin
        found = 1'b1;
        grant = chan_id_t'(i);
      end
    end
  end

  assign any_val     = |cache_req_val;
  assign mem_req_val = any_val & ~q_full;
  assign req_fire    = mem_req_val & mem_req_rdy;

  always_comb begin
    mem_req_msg   = cache_req_msg[0];
    cache_req_rdy = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      if (grant == chan_id_t'(i)) begin
        mem_req_msg      = cache_req_msg[i];
        cache_req_rdy[i] = any_val & mem_req_rdy & ~q_full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         rr_ptr <= '0;
    else if (req_fire) rr_ptr <= rr_next(grant, p_num_ports);
  end

  lab3_cache_TagQueue #(
    .p_depth (p_max_outstanding)
  ) u_tag_queue (
    .clk     (clk),
    .reset   (reset),
    .push    (req_fire),
    .push_id (grant),
    .pop     (resp_fire),
    .full    (q_full),
    .empty   (q_empty),
    .head    (q_head)
  );

  // Memory answers in request order, so the queue head owns the current response.
  always_comb begin
    head_rdy       = 1'b0;
    cache_resp_val = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      cache_resp_msg[i] = mem_resp_msg;
      if (q_head == chan_id_t'(i)) begin
        head_rdy          = cache_resp_rdy[i];
        cache_resp_val[i] = mem_resp_val & ~q_empty;
      end
    end
  end

  assign mem_resp_rdy = ~q_empty & head_rdy;
  assign resp_fire    = mem_resp_val & mem_resp_rdy;

  // flush_done also waits for write-backs issued during the flush to be acknowledged.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky     <= '0;
      flush_done <= 1'b0;
    end else if (!flush) begin
      sticky     <= '0;
      flush_done <= 1'b0;
    end else begin
      sticky     <= sticky | cache_flush_done;
      flush_done <= (&sticky) & q_empty;
    end
  end

endmodule
